uart_tx_arb: RTL

Round-robin, packet-granular arbiter sharing one UART transmitter between `p_req` byte-stream requesters. It sits in front of the UART TX instance. Each requester's packet is delimited by a `last` flag. The block captures each byte into a holding register and presents it to the transmitter with a stable valid/data pair until the transmitter's end-of-frame accept. A per-packet byte cap (`p_max_pkt`) stops one requester from monopolising the line.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default sizing.
package uart_pkg;

  localparam int P_REQ_DEF     = 4;
  localparam int P_MAX_PKT_DEF = 16;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    SEND = 2'd1,
    LOAD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module uart_rr_pick #(
  parameter int p_req = 4,
  parameter int IW    = $clog2(p_req)
) (
  input  logic [p_req-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [p_req-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic hit;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    j     = 0;
    for (int i = 0; i < p_req; i++) begin
      j = (int'(ptr_i) + i) % p_req;
      if (!hit && req_i[j]) begin
        hit      = 1'b1;
        idx_o    = IW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among requesters.
//   state | meaning
//   ARB   | no owner; pick next requester from ptr_q and capture its byte
//   SEND  | holding byte presented to the transmitter until its accept
//   LOAD  | owner keeps the line; wait for its next byte
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int p_req     = P_REQ_DEF,
  parameter int p_max_pkt = P_MAX_PKT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [p_req-1:0]     i_req_valid,
  input  logic [8*p_req-1:0]   i_req_data,
  input  logic [p_req-1:0]     i_req_last,
  output logic [p_req-1:0]     o_req_accept,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_accept,
  output logic [p_req-1:0]     o_grant,
  output logic                 o_busy
);

  localparam int IW = $clog2(p_req);

  arb_state_t       state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    idx_q;
  logic [p_req-1:0] grant_q;
  logic [7:0]       cnt_q;
  logic [7:0]       data_q;
  logic             last_q;

  logic [p_req-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    ptr_d;

  uart_rr_pick #(.p_req(p_req), .IW(IW)) u_pick (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign ptr_d = (idx_q == IW'(p_req - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (|pick_gnt) begin
            data_q  <= i_req_data[{pick_idx, 3'b000} +: 8];
            last_q  <= i_req_last[pick_idx];
            grant_q <= pick_gnt;
            idx_q   <= pick_idx;
            cnt_q   <= 8'd1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (i_tx_accept) begin
            // Release on end of packet or when the byte cap is used up.
            if (last_q || cnt_q == 8'(p_max_pkt)) begin
              grant_q <= '0;
              ptr_q   <= ptr_d;
              state_q <= ARB;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (i_req_valid[idx_q]) begin
            data_q  <= i_req_data[{idx_q, 3'b000} +: 8];
            last_q  <= i_req_last[idx_q];
            cnt_q   <= cnt_q + 8'd1;
            state_q <= SEND;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_comb begin
    o_req_accept = '0;
    if (state_q == ARB)       o_req_accept = pick_gnt;
    else if (state_q == LOAD) o_req_accept = grant_q & i_req_valid;
  end

  assign o_tx_valid = (state_q == SEND);
  assign o_tx_data  = data_q;
  assign o_grant    = grant_q;
  assign o_busy     = (state_q != ARB);

endmodule
